int_controller: RTL

INT_CONTROLLER -- requirements
Module: int_controller

---
 rtl/int_controller.sv | 88 ++++++++
 1 files changed

// File: rtl/int_controller.sv
// int_controller: prioritised, nesting interrupt controller with per-line edge/level
// capture, mask register, software clear and an in-service stack.
module int_controller #(
    parameter int NUM_IRQ = 8,
    parameter int ID_W = 5,
    parameter int NEST_DEPTH = 4,
    parameter logic [NUM_IRQ-1:0] EDGE_MODE = '0,
    localparam int DW = $clog2(NEST_DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic               mask_we,
    input  logic [NUM_IRQ-1:0] mask_wdata,
    input  logic               sw_clr,
    input  logic [ID_W-1:0]    sw_clr_id,
    input  logic               ack_start,
    input  logic [ID_W-1:0]    ack_start_id,
    input  logic               ack_end,
    input  logic [ID_W-1:0]    ack_end_id,
    output logic               int_flag,
    output logic [ID_W-1:0]    current_int_id,
    output logic [DW-1:0]      depth,
    output logic               proto_err
);
    localparam logic [NUM_IRQ-1:0] ONE = 1;
    localparam logic [DW-1:0] FULL = DW'(NEST_DEPTH);
    logic [NUM_IRQ-1:0] pending, in_service, mask, irq_prev;
    logic [NUM_IRQ-1:0] pending_nx, in_service_nx, set, cand;
    logic [NEST_DEPTH*ID_W-1:0] stack, stack_nx;
    logic [ID_W-1:0] top, top_pop, top_nx, win;
    logic [DW-1:0] d_pop, depth_nx;
    logic end_ok, start_ok, found, elig;
    // Priority and eligibility look at the post-acknowledge stack so that an
    // accepted start withdraws its request on the very edge it is taken.
    always_comb begin
        top = stack[(depth - DW'(1))*ID_W +: ID_W];
        end_ok = ack_end && depth != '0 && ack_end_id == top;
        d_pop = depth - (end_ok ? DW'(1) : DW'(0));
        top_pop = d_pop == '0 ? '0 : stack[(d_pop - DW'(1))*ID_W +: ID_W];
        start_ok = ack_start && int_flag && ack_start_id == current_int_id && d_pop < FULL
                   && (d_pop == '0 || ack_start_id < top_pop);
        depth_nx = d_pop + (start_ok ? DW'(1) : DW'(0));
        stack_nx = stack;
        if (start_ok)
            stack_nx[d_pop*ID_W +: ID_W] = ack_start_id;
        top_nx = stack_nx[(depth_nx - DW'(1))*ID_W +: ID_W];
        in_service_nx = (in_service & ~(end_ok ? ONE << ack_end_id : '0))
                        | (start_ok ? ONE << ack_start_id : '0);
        set = (EDGE_MODE & irq_in & ~irq_prev) | (~EDGE_MODE & irq_in & ~in_service);
        pending_nx = ((pending & ~(sw_clr ? ONE << sw_clr_id : '0)) | set)
                     & ~(start_ok ? ONE << ack_start_id : '0);
        cand = pending & mask & ~in_service_nx;
        win = '0;
        found = 1'b0;
        for (int i = NUM_IRQ - 1; i >= 0; i--)
            if (cand[i]) begin
                win = ID_W'(i);
                found = 1'b1;
            end
        elig = found && depth_nx < FULL && (depth_nx == '0 || win < top_nx);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
            in_service <= '0;
            mask <= '1;
            irq_prev <= '0;
            stack <= '0;
            depth <= '0;
            int_flag <= 1'b0;
            current_int_id <= '0;
            proto_err <= 1'b0;
        end else begin
            pending <= pending_nx;
            in_service <= in_service_nx;
            if (mask_we)
                mask <= mask_wdata;
            irq_prev <= irq_in;
            stack <= stack_nx;
            depth <= depth_nx;
            int_flag <= elig;
            if (elig)
                current_int_id <= win;
            proto_err <= (ack_start && !start_ok) || (ack_end && !end_ok);
        end
    end
endmodule
